// File: rtl/ssr_accumulate_if.sv
// Handshake bundle for the product accumulator: product stream in,
// completed sums out, plus the synchronous frame-abandon strobe.
interface ssr_accumulate_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ACC_LEN    = 16
);
   localparam int PROD_WIDTH = 2 * DATA_WIDTH;
   localparam int SUM_WIDTH  = PROD_WIDTH + $clog2(ACC_LEN);

   logic                  clr;
   logic                  in_valid;
   logic                  in_ready;
   logic [PROD_WIDTH-1:0] in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [SUM_WIDTH-1:0]  out_data;

   modport master (
      output clr,
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data
   );

   modport slave (
      input  clr,
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data
   );
endinterface

// File: rtl/ssr_accumulate.sv
// Sums ACC_LEN consecutive unsigned products into one widened result,
// with valid/ready on both sides and a one-deep output register.
module ssr_accumulate #(
   parameter int DATA_WIDTH = 32,
   parameter int ACC_LEN    = 16
) (
   input logic             clk,
   input logic             rst_n,
   ssr_accumulate_if.slave bus
);
   localparam int GUARD_BITS = $clog2(ACC_LEN);
   localparam int SUM_WIDTH  = 2 * DATA_WIDTH + GUARD_BITS;

   logic [SUM_WIDTH-1:0]  acc;
   logic [SUM_WIDTH-1:0]  sum;
   logic [SUM_WIDTH-1:0]  out_data;
   logic [GUARD_BITS-1:0] cnt;
   logic                  out_valid;
   logic                  last;
   logic                  in_ready;
   logic                  take;

   assign last = (cnt == GUARD_BITS'(ACC_LEN - 1));

   // Only the closing sample must wait for the output register to drain.
   assign in_ready = !(out_valid && last);
   assign take     = bus.in_valid && in_ready && !bus.clr;
   assign sum      = acc + SUM_WIDTH'(bus.in_data);

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_data  = out_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= '0;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         if (out_valid && bus.out_ready)
            out_valid <= 1'b0;
         if (bus.clr) begin
            acc <= '0;
            cnt <= '0;
         end else if (take) begin
            if (last) begin
               out_data  <= sum;
               out_valid <= 1'b1;
               acc       <= '0;
               cnt       <= '0;
            end else begin
               acc <= sum;
               cnt <= cnt + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_ssr_accumulate.sv
// Scoreboard bench: a queue-based frame model predicts sums and
// handshake levels; a separate monitor checks every presented result.
module tb_ssr_accumulate;
   localparam int DW = 8;
   localparam int AL = 4;

   logic clk = 1'b0;
   logic rst_n;

   ssr_accumulate_if #(.DATA_WIDTH(DW), .ACC_LEN(AL)) bus ();

   ssr_accumulate #(.DATA_WIDTH(DW), .ACC_LEN(AL)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int frame[$];
   int exp_q[$];
   bit ov = 1'b0;

   task automatic check(string name, longint act, longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, req);
      end
   endtask

   // Monitor: compares whatever result the DUT presents.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid) begin
         if (exp_q.size() == 0)
            check("spurious_result", 1, 0);
         else begin
            check("out_data", bus.out_data, exp_q[0]);
            if (bus.out_ready)
               void'(exp_q.pop_front());
         end
      end
   end

   // Reference model: frames are lists of accepted products.
   always @(negedge clk) begin : mdl
      bit ir;
      int s;
      #1;
      if (!rst_n) begin
         frame.delete();
         exp_q.delete();
         ov = 1'b0;
      end else begin
         ir = !(ov && frame.size() == AL - 1);
         check("in_ready", bus.in_ready, ir);
         check("out_valid", bus.out_valid, ov);
         if (ov && bus.out_ready)
            ov = 1'b0;
         if (bus.clr)
            frame.delete();
         else if (bus.in_valid && ir) begin
            frame.push_back(int'(bus.in_data));
            if (frame.size() == AL) begin
               s = frame.sum();
               exp_q.push_back(s);
               frame.delete();
               ov = 1'b1;
            end
         end
      end
   end

   task automatic cyc(bit v, int d, bit c);
      bus.in_valid = v;
      bus.in_data  = 16'(d);
      bus.clr      = c;
      @(posedge clk);
      #1;
   endtask

   task automatic send(int d);
      bit got;
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = 16'(d);
      bus.clr      = 1'b0;
      do begin
         @(negedge clk);
         got = bus.in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!got && n < 50);
      if (!got)
         check("send_timeout", 0, 1);
      bus.in_valid = 1'b0;
   endtask

   task automatic idle(int n);
      repeat (n) cyc(1'b0, 0, 1'b0);
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.clr       = 1'b0;
      bus.out_ready = 1'b1;
      #3;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_data", bus.out_data, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // basic frame
      for (int i = 1; i <= 4; i++) send(i);
      idle(3);

      // full-scale frame
      for (int i = 0; i < 4; i++) send(65025);
      idle(3);

      // backpressure
      bus.out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) send(i);
      for (int i = 0; i < 3; i++) send(5);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'd5;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_hold_data", bus.out_data, 10);
      bus.out_ready = 1'b1;
      send(5);
      idle(3);

      // clear mid-frame
      send(7);
      send(7);
      cyc(1'b1, 9, 1'b1);
      for (int i = 0; i < 4; i++) send(1);
      idle(3);

      // back-to-back frames
      for (int i = 0; i < 8; i++) send(1);
      idle(3);

      // reset mid-operation with a result pending
      bus.out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) send(i);
      send(2);
      send(2);
      idle(1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_out_valid", bus.out_valid, 0);
      check("rst_mid_in_ready", bus.in_ready, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) send(2);
      idle(3);

      // randomized traffic
      repeat (400) begin
         bus.out_ready = ($urandom_range(0, 3) != 0);
         cyc($urandom_range(0, 3) != 0,
             ($urandom_range(0, 3) == 0) ? 65535 : int'($urandom_range(0, 65535)),
             $urandom_range(0, 15) == 0);
      end

      bus.out_ready = 1'b1;
      idle(8);
      check("drain_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
